fmap_sram_writer: RTL and testbench
===================================

// Module: fmap_sram_writer
// PURPOSE
// - Parametrised feature-map write port for the LeNet accelerator. Generalises the fixed per-layer
//   SRAM B/C/D/E/F write ports: one byte per set per beat, 2-set dual datapath kept.
// - Accepts a raster-ordered output stream from the conv/pool/FC engine. Packs 4 channels per
//   32-bit word, interleaves columns across NUM_BANK banks and drives one-hot WE + bytemask + addr.
// - New vs. previous generation: runtime mode (CONV bank-interleaved / FC linear), valid-ready
//   handshake, start/busy/done sequencing.
// PARAMETERS
// - NUM_BANK  5   banks in the target SRAM group (9 for B, 5 for C/D/E, 1 for F)
// - NUM_SET   2   parallel data sets written per beat
// - DATA_W    8   bits per element
// - ADDR_W    10  SRAM word-address width
// - FMAP_W    12  conv-mode map width (columns)
// - FMAP_H    12  conv-mode map height (rows)
// - NUM_CH    6   conv-mode channel count
// - FC_LEN    120 FC-mode element count
// PORTS
// - clk               in   1                 clock, rising edge
// - rst               in   1                 asynchronous, active-high reset
// - start             in   1                 begin a pass; sampled only while idle
// - mode              in   1                 0 = CONV, 1 = FC; latched on accepted start
// - in_valid          in   1                 producer has a beat
// - in_ready          out  1                 = busy; beat accepted when in_valid & in_ready
// - in_data           in   NUM_SET*DATA_W    set s at [s*DATA_W +: DATA_W]
// - busy              out  1                 pass in progress
// - done              out  1                 one-cycle pulse, pass complete
// - sram_write_enable out  NUM_BANK          one-hot, active-high, registered
// - sram_bytemask     out  4                 one-hot byte lane, active-high, registered
// - sram_waddr        out  ADDR_W            registered word address
// - sram_wdata        out  NUM_SET*DATA_W    registered data, same for all banks
// BEHAVIOUR
// - Reset (async, rst=1): every output = 0, FSM = IDLE, all counters = 0.
// - FSM states and transitions:
//   - IDLE -> RUN on start; latch mode; clear counters.
//   - RUN -> DONE on acceptance of the last beat.
//   - DONE -> IDLE after one cycle; done=1 only in DONE.
// - start while RUN or DONE is ignored. rst mid-pass aborts immediately; no partial done.
// - Latency: accepted beat -> write signals valid on the next cycle, for exactly one cycle.
//   No accept -> WE = 0; addr, mask and data hold their last values.
// - CONV mode: stream order is col fastest, then row, then ch.
//   - CPB = ceil(FMAP_W/NUM_BANK).
//   - bank = col % NUM_BANK; lane = ch % 4.
//   - waddr = (ch/4)*FMAP_H*CPB + row*CPB + col/NUM_BANK.
//   - Derived incrementally: bank counter wraps at NUM_BANK and bumps col_div; row_base += CPB per row.
//   - End of a channel: ch%4 != 3 -> row_base reloads to grp_base; ch%4 == 3 -> grp_base += FMAP_H*CPB.
//   - Last beat: col=FMAP_W-1, row=FMAP_H-1, ch=NUM_CH-1. Total FMAP_W*FMAP_H*NUM_CH beats.
// - FC mode: bank 0 only; lane = idx % 4; waddr = idx / 4; FC_LEN beats.
// - Address arithmetic is modulo 2^ADDR_W (silent wrap). Not checked at run time.
// - done=1 and in_ready=0 in the same cycle. The beat after the last is never accepted.
// - in_data is forwarded unmodified; no saturation or arithmetic on data.
// STRUCTURE
// - Package lenet_pkg: mode enum (MODE_CONV, MODE_FC), FSM state enum, BYTES_PER_WORD = 4.
// - One sub-module fmap_addr_gen: counters plus bank/lane/addr generation for both modes,
//   with an advance strobe and a last flag.
// - Top level holds the FSM, handshake and output registers.
// TESTING (NUM_BANK=5, FMAP_W=7, FMAP_H=2, NUM_CH=5, FC_LEN=6 => CPB=2)
// - Reset: rst pulse mid-run -> all outputs 0 during rst; later start runs a full clean pass.
// - CONV beat #5 (col5,row0,ch0) -> next cycle WE=5'b00001, mask=4'b0001, waddr=1.
// - CONV beat (col3,row1,ch2) -> WE=5'b01000, mask=4'b0100, waddr=2.
//   Beat (col0,row0,ch4) -> mask=4'b0001, waddr=4.
// - Backpressure: in_valid random 50% -> exactly 70 writes, order unchanged.
//   done one cycle after the write of the 70th beat.
// - FC mode, 6 beats data 0x10..0x15 -> WE=00001 each time.
//   mask 0001,0010,0100,1000,0001,0010; waddr 0,0,0,0,1,1; then done.
// - start held high through a pass -> second pass starts only after IDLE.
//   Exactly one done per pass.

Source files
------------

// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared types and constants for the LeNet feature-map write port
package lenet_pkg;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_FC   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Counter width for values 0..n-1; never narrower than a byte-lane index.
  function automatic int cnt_w(input int n);
    return (n <= 4) ? 2 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_addr_gen.sv
// rtl/fmap_addr_gen.sv - raster counters producing bank, byte lane and word address
module fmap_addr_gen
  import lenet_pkg::*;
#(
  parameter int NUM_BANK = 5,
  parameter int ADDR_W   = 10,
  parameter int FMAP_W   = 12,
  parameter int FMAP_H   = 12,
  parameter int NUM_CH   = 6,
  parameter int FC_LEN   = 120
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      advance_i,
  input  mode_e                     mode_i,
  output logic [NUM_BANK-1:0]       bank_oh_o,
  output logic [BYTES_PER_WORD-1:0] lane_oh_o,
  output logic [ADDR_W-1:0]         waddr_o,
  output logic                      last_o
);

  localparam int CPB = (FMAP_W + NUM_BANK - 1) / NUM_BANK;
  localparam int BW  = cnt_w(NUM_BANK);
  localparam int CW  = cnt_w(FMAP_W);
  localparam int RW  = cnt_w(FMAP_H);
  localparam int HW  = cnt_w(NUM_CH);
  localparam int IW  = cnt_w(FC_LEN);
  localparam logic [ADDR_W-1:0] CPB_A    = ADDR_W'(CPB);
  localparam logic [ADDR_W-1:0] GRP_STEP = ADDR_W'(FMAP_H * CPB);

  logic [BW-1:0]     bank_q, bank_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] col_div_q, col_div_d;
  logic [RW-1:0]     row_q, row_d;
  logic [HW-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] grp_base_q, grp_base_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        lane;

  always_comb begin
    bank_d     = bank_q;
    col_d      = col_q;
    col_div_d  = col_div_q;
    row_d      = row_q;
    ch_d       = ch_q;
    row_base_d = row_base_q;
    grp_base_d = grp_base_q;
    idx_d      = idx_q;
    if (clear_i) begin
      bank_d     = '0;
      col_d      = '0;
      col_div_d  = '0;
      row_d      = '0;
      ch_d       = '0;
      row_base_d = '0;
      grp_base_d = '0;
      idx_d      = '0;
    end else if (advance_i) begin
      if (mode_i == MODE_FC) begin
        idx_d = idx_q + IW'(1);
      end else if (col_q == CW'(FMAP_W - 1)) begin
        col_d     = '0;
        bank_d    = '0;
        col_div_d = '0;
        if (row_q == RW'(FMAP_H - 1)) begin
          row_d = '0;
          ch_d  = ch_q + HW'(1);
          // Four channels share a word, so only every fourth channel opens a new address group.
          if (ch_q[1:0] == 2'd3) begin
            grp_base_d = grp_base_q + GRP_STEP;
            row_base_d = grp_base_q + GRP_STEP;
          end else begin
            row_base_d = grp_base_q;
          end
        end else begin
          row_d      = row_q + RW'(1);
          row_base_d = row_base_q + CPB_A;
        end
      end else begin
        col_d = col_q + CW'(1);
        if (bank_q == BW'(NUM_BANK - 1)) begin
          bank_d    = '0;
          col_div_d = col_div_q + ADDR_W'(1);
        end else begin
          bank_d = bank_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q     <= '0;
      col_q      <= '0;
      col_div_q  <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      row_base_q <= '0;
      grp_base_q <= '0;
      idx_q      <= '0;
    end else begin
      bank_q     <= bank_d;
      col_q      <= col_d;
      col_div_q  <= col_div_d;
      row_q      <= row_d;
      ch_q       <= ch_d;
      row_base_q <= row_base_d;
      grp_base_q <= grp_base_d;
      idx_q      <= idx_d;
    end
  end

  assign lane      = (mode_i == MODE_FC) ? idx_q[1:0] : ch_q[1:0];
  assign lane_oh_o = BYTES_PER_WORD'(1) << lane;
  assign bank_oh_o = (mode_i == MODE_FC) ? NUM_BANK'(1) : (NUM_BANK'(1) << bank_q);
  assign waddr_o   = (mode_i == MODE_FC) ? ADDR_W'(idx_q >> 2) : (row_base_q + col_div_q);
  assign last_o    = (mode_i == MODE_FC) ? (idx_q == IW'(FC_LEN - 1))
                   : ((col_q == CW'(FMAP_W - 1)) && (row_q == RW'(FMAP_H - 1))
                      && (ch_q == HW'(NUM_CH - 1)));

endmodule

// File: rtl/fmap_sram_writer.sv
// rtl/fmap_sram_writer.sv - feature-map SRAM write port with pass sequencing and handshake
module fmap_sram_writer
  import lenet_pkg::*;
#(
  parameter int NUM_BANK = 5,
  parameter int NUM_SET  = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int FMAP_W   = 12,
  parameter int FMAP_H   = 12,
  parameter int NUM_CH   = 6,
  parameter int FC_LEN   = 120
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SET*DATA_W-1:0]   in_data,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BANK-1:0]         sram_write_enable,
  output logic [BYTES_PER_WORD-1:0]   sram_bytemask,
  output logic [ADDR_W-1:0]           sram_waddr,
  output logic [NUM_SET*DATA_W-1:0]   sram_wdata
);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic   clear, accept, last;

  logic [NUM_BANK-1:0]       bank_oh;
  logic [BYTES_PER_WORD-1:0] lane_oh;
  logic [ADDR_W-1:0]         waddr;

  logic [NUM_BANK-1:0]       we_q;
  logic [BYTES_PER_WORD-1:0] mask_q;
  logic [ADDR_W-1:0]         waddr_q;
  logic [NUM_SET*DATA_W-1:0] wdata_q;

  fmap_addr_gen #(
    .NUM_BANK (NUM_BANK),
    .ADDR_W   (ADDR_W),
    .FMAP_W   (FMAP_W),
    .FMAP_H   (FMAP_H),
    .NUM_CH   (NUM_CH),
    .FC_LEN   (FC_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .advance_i (accept),
    .mode_i    (mode_q),
    .bank_oh_o (bank_oh),
    .lane_oh_o (lane_oh),
    .waddr_o   (waddr),
    .last_o    (last)
  );

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign in_ready = busy;
  assign accept   = in_valid && busy;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          clear   = 1'b1;
        end
      end
      ST_RUN:  if (accept && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CONV;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Write strobes last exactly one cycle; address, mask and data hold between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= '0;
      mask_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept ? bank_oh : '0;
      if (accept) begin
        mask_q  <= lane_oh;
        waddr_q <= waddr;
        wdata_q <= in_data;
      end
    end
  end

  assign sram_write_enable = we_q;
  assign sram_bytemask     = mask_q;
  assign sram_waddr        = waddr_q;
  assign sram_wdata        = wdata_q;

endmodule

// File: tb/tb_fmap_sram_writer.sv
// tb/tb_fmap_sram_writer.sv - directed self-checking bench for fmap_sram_writer
module tb_fmap_sram_writer;

  localparam int NB = 5;
  localparam int NS = 2;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int FW = 7;
  localparam int FH = 2;
  localparam int NC = 5;
  localparam int FL = 6;
  localparam int TOTAL = FW * FH * NC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [NS*DW-1:0]  in_data;
  logic              busy;
  logic              done;
  logic [NB-1:0]     sram_write_enable;
  logic [3:0]        sram_bytemask;
  logic [AW-1:0]     sram_waddr;
  logic [NS*DW-1:0]  sram_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fmap_sram_writer #(
    .NUM_BANK (NB), .NUM_SET (NS), .DATA_W (DW), .ADDR_W (AW),
    .FMAP_W (FW), .FMAP_H (FH), .NUM_CH (NC), .FC_LEN (FL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .mode              (mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .busy              (busy),
    .done              (done),
    .sram_write_enable (sram_write_enable),
    .sram_bytemask     (sram_bytemask),
    .sram_waddr        (sram_waddr),
    .sram_wdata        (sram_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] beat_data(input int n);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'(n);
    hi = 8'(n) ^ 8'h5A;
    return {hi, lo};
  endfunction

  function automatic int conv_addr(input int n);
    int col, row, ch;
    col = n % FW;
    row = (n / FW) % FH;
    ch  = n / (FW * FH);
    return (ch / 4) * FH * 2 + row * 2 + col / NB;
  endfunction

  task automatic chk_conv(input int n);
    int col, ch;
    col = n % FW;
    ch  = n / (FW * FH);
    chk($sformatf("conv%0d_we", n), 32'(sram_write_enable), 32'(1) << (col % NB));
    chk($sformatf("conv%0d_mask", n), 32'(sram_bytemask), 32'(1) << (ch % 4));
    chk($sformatf("conv%0d_waddr", n), 32'(sram_waddr), 32'(conv_addr(n)));
    chk($sformatf("conv%0d_wdata", n), 32'(sram_wdata), 32'(beat_data(n)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_we"}, 32'(sram_write_enable), 0);
    chk({tag, "_mask"}, 32'(sram_bytemask), 0);
    chk({tag, "_waddr"}, 32'(sram_waddr), 0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 0);
  endtask

  initial begin
    int n;
    int cyc;
    int hold_addr;
    int dones;
    int writes;
    logic v;
    logic acc;
    logic [3:0] fc_mask [6];
    logic [7:0] b0;
    logic [7:0] b1;

    fc_mask = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Partial pass aborted by an asynchronous reset.
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = beat_data(i);
      tick();
    end
    chk("pre_rst_waddr", 32'(sram_waddr), 2);
    chk("pre_rst_we", 32'(sram_write_enable), 32'b00001);
    #2 rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Full CONV pass, producer always valid.
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("conv_busy", 32'(busy), 1);
    for (int i = 0; i < TOTAL; i++) begin
      in_valid = 1'b1; in_data = beat_data(i);
      tick();
      chk_conv(i);
      if (i == 5) begin
        chk("b5_we", 32'(sram_write_enable), 32'b00001);
        chk("b5_mask", 32'(sram_bytemask), 32'b0001);
        chk("b5_waddr", 32'(sram_waddr), 1);
      end
      if (i == 38) begin
        chk("b38_we", 32'(sram_write_enable), 32'b01000);
        chk("b38_mask", 32'(sram_bytemask), 32'b0100);
        chk("b38_waddr", 32'(sram_waddr), 2);
      end
      if (i == 56) begin
        chk("b56_mask", 32'(sram_bytemask), 32'b0001);
        chk("b56_waddr", 32'(sram_waddr), 4);
      end
      if (i < TOTAL - 1) chk("conv_no_early_done", 32'(done), 0);
    end
    chk("conv_done", 32'(done), 1);
    chk("conv_done_ready", 32'(in_ready), 0);
    tick();
    chk("after_last_we", 32'(sram_write_enable), 0);
    chk("after_last_done", 32'(done), 0);
    chk("after_last_busy", 32'(busy), 0);
    in_valid = 1'b0;

    // CONV pass with random producer stalls.
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    n = 0; cyc = 0; hold_addr = 7;
    while (n < TOTAL && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = v ? beat_data(n) : 16'hDEAD;
      acc = v && in_ready;
      tick();
      cyc++;
      if (acc) begin
        chk_conv(n);
        hold_addr = conv_addr(n);
        n++;
        chk("bp_done", 32'(done), (n == TOTAL) ? 1 : 0);
      end else begin
        chk("bp_idle_we", 32'(sram_write_enable), 0);
        chk("bp_hold_waddr", 32'(sram_waddr), 32'(hold_addr));
      end
    end
    in_valid = 1'b0;
    chk("bp_write_count", 32'(n), 32'(TOTAL));
    tick();
    chk("bp_done_clear", 32'(done), 0);

    // FC pass; mode input changes after start to show it is latched.
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int i = 0; i < FL; i++) begin
      b0 = 8'h10 + 8'(i);
      b1 = 8'hA0 + 8'(i);
      in_valid = 1'b1; in_data = {b1, b0};
      tick();
      chk($sformatf("fc%0d_we", i), 32'(sram_write_enable), 32'b00001);
      chk($sformatf("fc%0d_mask", i), 32'(sram_bytemask), 32'(fc_mask[i]));
      chk($sformatf("fc%0d_waddr", i), 32'(sram_waddr), 32'(i / 4));
      chk($sformatf("fc%0d_wdata", i), 32'(sram_wdata), 32'({b1, b0}));
    end
    chk("fc_done", 32'(done), 1);
    in_valid = 1'b0;
    tick();

    // start held high across two FC passes.
    start = 1'b1; mode = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
    dones = 0; writes = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (done) dones++;
      if (sram_write_enable != '0) writes++;
      if (c == 6)  chk("held_done1", 32'(done), 1);
      if (c == 7)  chk("held_idle_busy", 32'(busy), 0);
      if (c == 8)  chk("held_restart_busy", 32'(busy), 1);
      if (c == 14) chk("held_done2", 32'(done), 1);
    end
    start = 1'b0; in_valid = 1'b0;
    tick();
    chk("held_final_busy", 32'(busy), 0);
    chk("held_done_count", 32'(dones), 2);
    chk("held_write_count", 32'(writes), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
